vector_execution_pipe: RTL and testbench
========================================

// Module: vector_execution_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single-cycle vector execute stage. Accepts one vector
//  µop per cycle over a valid/ready handshake and executes SEW-aware element-wise integer ops on a
//  DATA_LENGTH-bit register slice. Produces in-order results through a fixed 2-stage pipeline
//  with full back-pressure. Sits between vector decode/issue and vector writeback.
// PARAMETERS
//  DATA_LENGTH  128  slice width in bits; multiple of 64
//  TAG_W        4    width of issue tag carried alongside each µop
//  MASK_W       DATA_LENGTH/8  mask bits, one per element at SEW=8 (derived; not overridable)
// PORTS
//  clk_i        in   1            clock, all logic on rising edge
//  rst_i        in   1            synchronous, active-high reset
//  in_valid_i   in   1            µop presented
//  in_ready_o   out  1            stage 1 can accept
//  op_i         in   4            0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 MERGE,6 MACC,7 MIN,8 MAX,9 SADDU,10 SSUBU
//  vsew_i       in   2            00=8,01=16,10=32,11=64-bit elements
//  vm_i         in   1            1 = unmasked; 0 = use vmask_i
//  tag_i        in   TAG_W        issue tag, returned unchanged
//  vs1_i/vs2_i/vd_i in DATA_LENGTH operands; vd_i is old destination (MACC addend, undisturbed source)
//  vmask_i      in   MASK_W       element mask, bit k -> element k
//  out_valid_o  out  1            result valid
//  out_ready_i  in   1            writeback accepts
//  vd_o         out  DATA_LENGTH  result slice
//  tag_o        out  TAG_W        tag of result
//  illegal_o    out  1            result came from an unsupported opcode
//  sat_o        out  1            any element saturated (SADDU/SSUBU only)
// BEHAVIOUR
//  - Reset: s1/s2 valid=0; out_valid_o=0, vd_o=0, tag_o=0, illegal_o=0, sat_o=0; in_ready_o=1 after reset.
//  - Transfer on valid&&ready, both sides. Latency exactly 2 cycles from input accept to out_valid_o
//    when unstalled; throughput 1/cycle.
//  - Stage 1 registers operands + decoded op; computes element products (MACC, low SEW bits of vs1*vs2).
//    Stage 2 registers final result (add/logic/merge/minmax/sat, MACC = vd + prod, mod 2^SEW).
//  - Advance: s2_en = !s2_valid || out_ready_i; s1_en = !s1_valid || s2_en; in_ready_o = s1_en
//    (combinational from out_ready_i). Stalled stages hold all outputs stable; out_valid_o never
//    drops without out_ready_i.
//  - Arithmetic wraps modulo 2^SEW per element; no carry crosses element boundaries. MIN/MAX signed.
//    SUB = vs2 - vs1. MERGE: elem = vmask[k] ? vs1 : vs2, ignores vm_i.
//  - Masking (vm_i=0, op!=MERGE): element k with vmask_i[k]=0 takes vd_i element (undisturbed).
//    Only low DATA_LENGTH/SEW mask bits used; upper bits ignored.
//  - Unsupported/reserved opcode (11-15, or 9-10 without macro): vd_o=0, illegal_o=1, tag passed,
//    result still emitted in order.
//  - Reset mid-operation: all in-flight µops discarded, no output produced for them.
// CONFIGURATION
//  VEXE_SAT_EN defined: ops 9/10 are unsigned saturating add/sub (clamp to 2^SEW-1 / 0); sat_o=1
//    if any active (unmasked) element clamped.
//  VEXE_SAT_EN undefined: ops 9/10 are illegal as above; sat_o tied 0; no saturation logic.
// TESTING
//  1 ADD SEW=8, vs1=all 0x01, vs2=all 0xFF, vm=1 -> vd_o all 0x00 two cycles later, no carry ripple.
//  2 MACC SEW=32, vs1=3, vs2=5, vd=7 per element -> vd_o elements 22; tag 0xA returned as 0xA.
//  3 Back-pressure: issue 4 µops back-to-back, out_ready_i=0 for 3 cycles -> in_ready_o=0 after
//    2 accepted, outputs held stable, all 4 results delivered in order once ready returns.
//  4 Masked SUB SEW=16, vm=0, vmask=0x00AA -> odd elements vs2-vs1, even elements equal vd_i.
//  5 Op=12 -> vd_o=0, illegal_o=1; reset asserted with 2 µops in flight -> out_valid_o=0 next cycle.
//  6 VEXE_SAT_EN: SADDU SEW=8, 0xF0+0x20 -> 0xFF, sat_o=1; without macro -> illegal_o=1.

Source files
------------

// File: rtl/vector_execution_pipe_if.sv
// Handshake and operand bundle for vector_execution_pipe.
// master drives micro-ops and accepts results; slave is the execution pipe.
interface vector_execution_pipe_if #(
    parameter int DATA_LENGTH = 128,
    parameter int TAG_W       = 4
);
    localparam int MASK_W = DATA_LENGTH / 8;

    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [3:0]             op_i;
    logic [1:0]             vsew_i;
    logic                   vm_i;
    logic [TAG_W-1:0]       tag_i;
    logic [DATA_LENGTH-1:0] vs1_i;
    logic [DATA_LENGTH-1:0] vs2_i;
    logic [DATA_LENGTH-1:0] vd_i;
    logic [MASK_W-1:0]      vmask_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [DATA_LENGTH-1:0] vd_o;
    logic [TAG_W-1:0]       tag_o;
    logic                   illegal_o;
    logic                   sat_o;

    modport master (
        output in_valid_i, op_i, vsew_i, vm_i, tag_i, vs1_i, vs2_i, vd_i, vmask_i, out_ready_i,
        input  in_ready_o, out_valid_o, vd_o, tag_o, illegal_o, sat_o
    );

    modport slave (
        input  in_valid_i, op_i, vsew_i, vm_i, tag_i, vs1_i, vs2_i, vd_i, vmask_i, out_ready_i,
        output in_ready_o, out_valid_o, vd_o, tag_o, illegal_o, sat_o
    );
endinterface

// File: rtl/vector_execution_pipe.sv
// vector_execution_pipe: 2-stage SEW-aware element-wise vector integer execute.
// Stage 1 registers operands, decode and per-element products; stage 2 registers the result.
// Optional macro VEXE_SAT_EN enables unsigned saturating add/sub (ops 9/10) and sat_o.

// One element of width W: computes the op result, applies masking, flags saturation.
module vexe_elem #(
    parameter int W = 8
) (
    input  logic [3:0]   op,
    input  logic         active,
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] d,
    input  logic [W-1:0] p,
    output logic [W-1:0] res,
    output logic         sat
);
`ifdef VEXE_SAT_EN
    logic [W:0] sum;
`endif

    // element result; inactive elements keep the old destination (merge excepted)
    always_comb begin
        res = '0;
        sat = 1'b0;
`ifdef VEXE_SAT_EN
        sum = '0;
`endif
        case (op)
            4'd0: res = b + a;
            4'd1: res = b - a;
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = sel ? a : b;
            4'd6: res = d + p;
            4'd7: res = ($signed(a) < $signed(b)) ? a : b;
            4'd8: res = ($signed(a) > $signed(b)) ? a : b;
`ifdef VEXE_SAT_EN
            4'd9: begin
                sum = {1'b0, a} + {1'b0, b};
                sat = sum[W];
                res = sat ? '1 : sum[W-1:0];
            end
            4'd10: begin
                sat = (b < a);
                res = sat ? '0 : b - a;
            end
`endif
            default: res = '0;
        endcase
        if (op != 4'd5 && !active) begin
            res = d;
            sat = 1'b0;
        end
    end
endmodule

module vector_execution_pipe #(
    parameter int DATA_LENGTH = 128,
    parameter int TAG_W       = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    vector_execution_pipe_if.slave  bus
);
    localparam int MASK_W = DATA_LENGTH / 8;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [3:0]             op;
        logic [1:0]             sew;
        logic                   vm;
        logic                   illegal;
        logic [TAG_W-1:0]       tag;
        logic [MASK_W-1:0]      vmask;
        logic [DATA_LENGTH-1:0] vs1;
        logic [DATA_LENGTH-1:0] vs2;
        logic [DATA_LENGTH-1:0] vd;
        logic [DATA_LENGTH-1:0] prod;
    } s1_t;

    typedef struct packed {
        logic [DATA_LENGTH-1:0] vd;
        logic [TAG_W-1:0]       tag;
        logic                   illegal;
        logic                   sat;
    } s2_t;

    // Low SEW bits of each element product, no cross-element interaction.
    function automatic logic [DATA_LENGTH-1:0] mul_slice(input logic [DATA_LENGTH-1:0] a,
                                                         input logic [DATA_LENGTH-1:0] b,
                                                         input logic [1:0]             sew);
        logic [DATA_LENGTH-1:0] p;
        p = '0;
        case (sew)
            2'd0: for (int i = 0; i < DATA_LENGTH/8; i++)  p[i*8 +: 8]   = a[i*8 +: 8]   * b[i*8 +: 8];
            2'd1: for (int i = 0; i < DATA_LENGTH/16; i++) p[i*16 +: 16] = a[i*16 +: 16] * b[i*16 +: 16];
            2'd2: for (int i = 0; i < DATA_LENGTH/32; i++) p[i*32 +: 32] = a[i*32 +: 32] * b[i*32 +: 32];
            default: for (int i = 0; i < DATA_LENGTH/64; i++) p[i*64 +: 64] = a[i*64 +: 64] * b[i*64 +: 64];
        endcase
        return p;
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
`ifdef VEXE_SAT_EN
        return op > 4'd10;
`else
        return op > 4'd8;
`endif
    endfunction

    logic [STAGES:1]             vld_pipe;
    logic                        s1_en, s2_en;
    s1_t                         s1_d, s1_q;
    s2_t                         s2_d, s2_q;
    logic [3:0][DATA_LENGTH-1:0] res_sew;
    logic [3:0]                  sat_any;

    assign s2_en         = !vld_pipe[2] || bus.out_ready_i;
    assign s1_en         = !vld_pipe[1] || s2_en;
    assign bus.in_ready_o = s1_en;

    // stage-1 capture: decode and element products
    always_comb begin
        s1_d         = '0;
        s1_d.op      = bus.op_i;
        s1_d.sew     = bus.vsew_i;
        s1_d.vm      = bus.vm_i;
        s1_d.illegal = is_illegal(bus.op_i);
        s1_d.tag     = bus.tag_i;
        s1_d.vmask   = bus.vmask_i;
        s1_d.vs1     = bus.vs1_i;
        s1_d.vs2     = bus.vs2_i;
        s1_d.vd      = bus.vd_i;
        s1_d.prod    = mul_slice(bus.vs1_i, bus.vs2_i, bus.vsew_i);
    end

    // one datapath per SEW; element e uses global mask bit e, so upper mask bits drop out
    for (genvar g = 0; g < 4; g++) begin : g_sew
        localparam int W  = 8 << g;
        localparam int NE = DATA_LENGTH / W;
        logic [NE-1:0] sat_e;
        for (genvar e = 0; e < NE; e++) begin : g_elem
            vexe_elem #(.W(W)) u_elem (
                .op     (s1_q.op),
                .active (s1_q.vm | s1_q.vmask[e]),
                .sel    (s1_q.vmask[e]),
                .a      (s1_q.vs1[e*W +: W]),
                .b      (s1_q.vs2[e*W +: W]),
                .d      (s1_q.vd[e*W +: W]),
                .p      (s1_q.prod[e*W +: W]),
                .res    (res_sew[g][e*W +: W]),
                .sat    (sat_e[e])
            );
        end
        assign sat_any[g] = |sat_e;
    end

    // stage-2 capture: select the active SEW, zero illegal results
    always_comb begin
        s2_d         = '0;
        s2_d.tag     = s1_q.tag;
        s2_d.illegal = s1_q.illegal;
        if (!s1_q.illegal) begin
            s2_d.vd  = res_sew[s1_q.sew];
            s2_d.sat = sat_any[s1_q.sew];
        end
    end

    // valid shift register; a stalled stage keeps its bit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
        end else begin
            if (s1_en) vld_pipe[1] <= bus.in_valid_i;
            if (s2_en) vld_pipe[2] <= vld_pipe[1];
        end
    end

    // stage-1 data, loaded only on accept; never visible so no reset needed
    always_ff @(posedge clk_i) begin
        if (s1_en && bus.in_valid_i) s1_q <= s1_d;
    end

    // stage-2 data drives the outputs directly, so it is cleared on reset
    always_ff @(posedge clk_i) begin
        if (rst_i)                     s2_q <= '0;
        else if (s2_en && vld_pipe[1]) s2_q <= s2_d;
    end

    assign bus.out_valid_o = vld_pipe[2];
    assign bus.vd_o        = s2_q.vd;
    assign bus.tag_o       = s2_q.tag;
    assign bus.illegal_o   = s2_q.illegal;
`ifdef VEXE_SAT_EN
    assign bus.sat_o       = s2_q.sat;
`else
    assign bus.sat_o       = 1'b0;
`endif
endmodule

// File: tb/tb_vector_execution_pipe.sv
// Directed bench for vector_execution_pipe (DATA_LENGTH=128, TAG_W=4).
module tb_vector_execution_pipe;
    localparam int DL = 128;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    vector_execution_pipe_if #(.DATA_LENGTH(DL), .TAG_W(4)) bus ();

    vector_execution_pipe #(.DATA_LENGTH(DL), .TAG_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic set_uop(input logic [3:0] op, input logic [1:0] sew, input logic vm,
                           input logic [3:0] tag, input logic [DL-1:0] vs1, input logic [DL-1:0] vs2,
                           input logic [DL-1:0] vd, input logic [15:0] mask);
        bus.op_i = op; bus.vsew_i = sew; bus.vm_i = vm; bus.tag_i = tag;
        bus.vs1_i = vs1; bus.vs2_i = vs2; bus.vd_i = vd; bus.vmask_i = mask;
        bus.in_valid_i = 1'b1;
    endtask

    // Present one uop, return out_valid seen one cycle later; leaves the result on the outputs.
    task automatic issue_wait(input logic [3:0] op, input logic [1:0] sew, input logic vm,
                              input logic [3:0] tag, input logic [DL-1:0] vs1, input logic [DL-1:0] vs2,
                              input logic [DL-1:0] vd, input logic [15:0] mask, output logic mid_vld);
        @(negedge clk);
        set_uop(op, sew, vm, tag, vs1, vs2, vd, mask);
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1 mid_vld = bus.out_valid_o;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (bus.out_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", bus.out_valid_o); end
        tests++; if (bus.vd_o !== '0) begin fails++; $display("FAIL reset_vd got %h exp 0", bus.vd_o); end
        tests++; if ({bus.tag_o, bus.illegal_o, bus.sat_o} !== 6'd0) begin fails++; $display("FAIL reset_flags got %b exp 0", {bus.tag_o, bus.illegal_o, bus.sat_o}); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        tests++; if (bus.in_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", bus.in_ready_o); end
    endtask

    task automatic test_add;
        logic mid;
        issue_wait(4'd0, 2'd0, 1'b1, 4'h3, {16{8'h01}}, {16{8'hFF}}, '0, '0, mid);
        tests++; if (mid !== 1'b0) begin fails++; $display("FAIL add8_latency got %b exp 0", mid); end
        tests++; if (bus.out_valid_o !== 1'b1) begin fails++; $display("FAIL add8_valid got %b exp 1", bus.out_valid_o); end
        tests++; if (bus.vd_o !== '0) begin fails++; $display("FAIL add8_vd got %h exp 0", bus.vd_o); end
        tests++; if (bus.tag_o !== 4'h3 || bus.illegal_o !== 1'b0) begin fails++; $display("FAIL add8_tag got %h/%b exp 3/0", bus.tag_o, bus.illegal_o); end
        issue_wait(4'd0, 2'd3, 1'b1, 4'h4, {2{64'h1}}, {2{64'h0000_0000_FFFF_FFFF}}, '0, '0, mid);
        tests++; if (bus.vd_o !== {2{64'h0000_0001_0000_0000}}) begin fails++; $display("FAIL add64_vd got %h exp %h", bus.vd_o, {2{64'h0000_0001_0000_0000}}); end
    endtask

    task automatic test_macc;
        logic mid;
        issue_wait(4'd6, 2'd2, 1'b1, 4'hA, {4{32'd3}}, {4{32'd5}}, {4{32'd7}}, '0, mid);
        tests++; if (bus.vd_o !== {4{32'd22}}) begin fails++; $display("FAIL macc32_vd got %h exp %h", bus.vd_o, {4{32'd22}}); end
        tests++; if (bus.tag_o !== 4'hA) begin fails++; $display("FAIL macc32_tag got %h exp a", bus.tag_o); end
    endtask

    task automatic test_minmax;
        logic mid;
        issue_wait(4'd7, 2'd0, 1'b1, 4'h1, {16{8'h80}}, {16{8'h01}}, '0, '0, mid);
        tests++; if (bus.vd_o !== {16{8'h80}}) begin fails++; $display("FAIL min8_vd got %h exp %h", bus.vd_o, {16{8'h80}}); end
        issue_wait(4'd8, 2'd0, 1'b1, 4'h2, {16{8'h80}}, {16{8'h01}}, '0, '0, mid);
        tests++; if (bus.vd_o !== {16{8'h01}}) begin fails++; $display("FAIL max8_vd got %h exp %h", bus.vd_o, {16{8'h01}}); end
    endtask

    task automatic test_masked_sub;
        logic mid;
        logic [DL-1:0] exp;
        for (int k = 0; k < 8; k++) exp[k*16 +: 16] = (k % 2 == 1) ? 16'hFFFE : 16'hBEEF;
        issue_wait(4'd1, 2'd1, 1'b0, 4'h6, {8{16'h0003}}, {8{16'h0001}}, {8{16'hBEEF}}, 16'h00AA, mid);
        tests++; if (bus.vd_o !== exp) begin fails++; $display("FAIL msub16_vd got %h exp %h", bus.vd_o, exp); end
    endtask

    task automatic test_merge;
        logic mid;
        logic [DL-1:0] exp;
        exp = {32'h2222_2222, 32'h1111_1111, 32'h2222_2222, 32'h1111_1111};
        issue_wait(4'd5, 2'd2, 1'b1, 4'h7, {4{32'h1111_1111}}, {4{32'h2222_2222}}, '0, 16'hFFF5, mid);
        tests++; if (bus.vd_o !== exp) begin fails++; $display("FAIL merge32_vd got %h exp %h", bus.vd_o, exp); end
    endtask

    task automatic test_back_to_back;
        int in_idx = 0;
        int out_idx = 0;
        logic [7:0] e8;
        logic [7:0] b8;
        for (int cyc = 0; cyc < 40 && out_idx < 4; cyc++) begin
            @(negedge clk);
            bus.out_ready_i = (cyc >= 3);
            if (in_idx < 4) begin
                b8 = 8'(in_idx);
                set_uop(4'd0, 2'd0, 1'b1, 4'(in_idx + 1), {16{b8}}, {16{8'h10}}, '0, '0);
            end else begin
                bus.in_valid_i = 1'b0;
            end
            #1;
            if (cyc == 2) begin
                tests++; if (bus.in_ready_o !== 1'b0 || in_idx != 2) begin fails++; $display("FAIL b2b_stall got ready=%b accepted=%0d exp 0/2", bus.in_ready_o, in_idx); end
                tests++; if (bus.out_valid_o !== 1'b1) begin fails++; $display("FAIL b2b_stall_valid got %b exp 1", bus.out_valid_o); end
            end
            if (bus.out_valid_o) begin
                e8 = 8'h10 + 8'(out_idx);
                tests++; if (bus.vd_o !== {16{e8}} || bus.tag_o !== 4'(out_idx + 1)) begin fails++; $display("FAIL b2b_out%0d got %h/%h exp %h/%h", out_idx, bus.vd_o, bus.tag_o, {16{e8}}, 4'(out_idx + 1)); end
                if (bus.out_ready_i) out_idx++;
            end
            if (bus.in_valid_i && bus.in_ready_o) in_idx++;
        end
        tests++; if (out_idx != 4) begin fails++; $display("FAIL b2b_count got %0d exp 4", out_idx); end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
    endtask

    task automatic test_illegal;
        logic mid;
        issue_wait(4'd12, 2'd0, 1'b1, 4'h5, {16{8'h5A}}, {16{8'h33}}, '1, '0, mid);
        tests++; if (bus.vd_o !== '0 || bus.illegal_o !== 1'b1) begin fails++; $display("FAIL ill12 got %h/%b exp 0/1", bus.vd_o, bus.illegal_o); end
        tests++; if (bus.tag_o !== 4'h5 || bus.out_valid_o !== 1'b1) begin fails++; $display("FAIL ill12_tag got %h/%b exp 5/1", bus.tag_o, bus.out_valid_o); end
        issue_wait(4'd9, 2'd0, 1'b1, 4'h9, {16{8'h20}}, {16{8'hF0}}, '0, '0, mid);
`ifdef VEXE_SAT_EN
        tests++; if (bus.vd_o !== {16{8'hFF}} || bus.sat_o !== 1'b1 || bus.illegal_o !== 1'b0) begin fails++; $display("FAIL saddu8 got %h/%b/%b exp ff../1/0", bus.vd_o, bus.sat_o, bus.illegal_o); end
        issue_wait(4'd10, 2'd0, 1'b1, 4'h8, {16{8'h10}}, {16{8'h30}}, '0, '0, mid);
        tests++; if (bus.vd_o !== {16{8'h20}} || bus.sat_o !== 1'b0) begin fails++; $display("FAIL ssubu8 got %h/%b exp 20../0", bus.vd_o, bus.sat_o); end
`else
        tests++; if (bus.vd_o !== '0 || bus.illegal_o !== 1'b1 || bus.sat_o !== 1'b0) begin fails++; $display("FAIL op9_illegal got %h/%b/%b exp 0/1/0", bus.vd_o, bus.illegal_o, bus.sat_o); end
`endif
    endtask

    task automatic test_reset_inflight;
        logic seen = 1'b0;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        set_uop(4'd4, 2'd0, 1'b1, 4'hB, {16{8'hFF}}, {16{8'h0F}}, '0, '0);
        @(negedge clk);
        set_uop(4'd2, 2'd0, 1'b1, 4'hC, {16{8'hFF}}, {16{8'h0F}}, '0, '0);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        tests++; if (bus.out_valid_o !== 1'b1 || bus.vd_o !== {16{8'hF0}}) begin fails++; $display("FAIL inflight_pre got %b/%h exp 1/f0..", bus.out_valid_o, bus.vd_o); end
        rst = 1'b1;
        @(negedge clk);
        #1;
        tests++; if (bus.out_valid_o !== 1'b0 || bus.vd_o !== '0) begin fails++; $display("FAIL inflight_rst got %b/%h exp 0/0", bus.out_valid_o, bus.vd_o); end
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (bus.out_valid_o) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL inflight_drop got %b exp 0", seen); end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
        bus.op_i = '0; bus.vsew_i = '0; bus.vm_i = 1'b1; bus.tag_i = '0;
        bus.vs1_i = '0; bus.vs2_i = '0; bus.vd_i = '0; bus.vmask_i = '0;
        test_reset;
        test_add;
        test_macc;
        test_minmax;
        test_masked_sub;
        test_merge;
        test_back_to_back;
        test_illegal;
        test_reset_inflight;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
